// File: rtl/upc_display_sequencer_if.sv
// Scanner-side bundle for the UPC display sequencer.
//   scan_valid/scan_code/scan_ready : ready/valid push of 3-bit item codes
//   hold/skip                       : display flow control
//   bcd/disp_en                     : code and enable towards the HEX UPC decoder
//   err                             : one-cycle pulse when an illegal code is discarded
//   count                           : entries waiting behind the displayed item
interface upc_display_sequencer_if #(
  parameter int DEPTH = 4
);
  logic                     scan_valid;
  logic [2:0]               scan_code;
  logic                     scan_ready;
  logic                     hold;
  logic                     skip;
  logic [2:0]               bcd;
  logic                     disp_en;
  logic                     err;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output scan_valid, scan_code, hold, skip,
    input  scan_ready, bcd, disp_en, err, count
  );

  modport slave (
    input  scan_valid, scan_code, hold, skip,
    output scan_ready, bcd, disp_en, err, count
  );
endinterface

// File: rtl/upc_display_sequencer.sv
// Queues legal UPC item codes and presents them one at a time to the HEX UPC
// decoder, each for DWELL cycles. Codes 2 and 7 are dropped with an err pulse
// so the decoder never receives an undefined input.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : upc_display_sequencer_if.slave (scan push, hold/skip, display outputs)
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | nothing displayed (disp_en=0), waiting for a queued item
// S_SHOW | bcd live; dwell counter running unless hold is asserted
module upc_display_sequencer #(
  parameter int DEPTH = 4,
  parameter int DWELL = 50_000_000,
  parameter int CW    = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  upc_display_sequencer_if.slave bus
);
  localparam int              AW   = $clog2(DEPTH);
  localparam logic [CW-1:0]   LAST = CW'(DWELL - 1);
  localparam logic [AW:0]     FULL = (AW + 1)'(DEPTH);

  typedef enum logic {S_IDLE, S_SHOW} state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [2:0]     r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_bcd;
  logic           r_disp_en;
  logic           r_err;

  logic           w_ready;
  logic           w_legal;
  logic           w_hs;
  logic           w_push;
  logic           w_reject;
  logic           w_empty;
  logic           w_item_end;
  logic           w_pop;
  logic           w_cnt_clr;
  logic           w_cnt_inc;
  logic           w_disp_en_nxt;

  // Readiness looks only at the registered count, so a pop in the same
  // cycle never opens a slot for the push.
  assign w_ready    = (r_count != FULL);
  assign w_legal    = (bus.scan_code != 3'd2) && (bus.scan_code != 3'd7);
  assign w_hs       = bus.scan_valid & w_ready;
  assign w_push     = w_hs & w_legal;
  assign w_reject   = w_hs & ~w_legal;
  assign w_empty    = (r_count == '0);
  // Skip and dwell expiry collapse into one end-of-item event; hold masks both.
  assign w_item_end = ~bus.hold & ((r_cnt == LAST) | bus.skip);

  always_comb begin
    w_next_state  = r_state;
    w_pop         = 1'b0;
    w_cnt_clr     = 1'b0;
    w_cnt_inc     = 1'b0;
    w_disp_en_nxt = r_disp_en;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && !bus.hold) begin
          w_pop         = 1'b1;
          w_cnt_clr     = 1'b1;
          w_disp_en_nxt = 1'b1;
          w_next_state  = S_SHOW;
        end
      end
      S_SHOW: begin
        if (w_item_end) begin
          w_cnt_clr = 1'b1;
          if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_disp_en_nxt = 1'b0;
            w_next_state  = S_IDLE;
          end
        end else if (!bus.hold) begin
          w_cnt_inc = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_cnt     <= '0;
      r_bcd     <= 3'd0;
      r_disp_en <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_disp_en <= w_disp_en_nxt;
      r_err     <= w_reject;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_bcd    <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Queue storage carries no reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.scan_code;
    end
  end

  assign bus.scan_ready = w_ready;
  assign bus.bcd        = r_bcd;
  assign bus.disp_en    = r_disp_en;
  assign bus.err        = r_err;
  assign bus.count      = r_count;
endmodule
